// File: rtl/conv_encoder.sv
// Rate-1/2 convolutional encoder with programmable generators.
// Newest bit enters sr at the MSB; each output bit is the parity of mask & sr.
module conv_encoder #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         data_in,
    input  logic [1:0]   load_mask,
    input  logic [N-1:0] mask,
    output logic [1:0]   data_out
);

    logic [N-1:0] sr;
    logic [N-1:0] m0;
    logic [N-1:0] m1;

    // History shift: clear on reset, else shift data_in in at the MSB
    always_ff @(posedge clk) begin
        if (!reset) begin
            sr <= '0;
        end else begin
            sr <= {data_in, sr[N-1:1]};
        end
    end

    // Generator masks: load on strobe, untouched by reset
    always_ff @(posedge clk) begin
        if (load_mask[0]) begin
            m0 <= mask;
        end
        if (load_mask[1]) begin
            m1 <= mask;
        end
    end

    // Parity of the tapped history bits, no output register
    always_comb begin
        data_out    = 2'b00;
        data_out[0] = ^(m0 & sr);
        data_out[1] = ^(m1 & sr);
    end

endmodule

// File: tb/tb_conv_encoder.sv
// Bench for conv_encoder: directed vector table plus a random
// regression against a queue-based history model.
module tb_conv_encoder;

    localparam int N = 4;

    logic         clk;
    logic         reset;
    logic         data_in;
    logic [1:0]   load_mask;
    logic [N-1:0] mask;
    logic [1:0]   data_out;

    int n_cmp;
    int n_err;

    typedef struct {
        logic         rst;
        logic         d;
        logic [1:0]   lm;
        logic [N-1:0] mk;
        logic [1:0]   exp;
    } vec_t;

    vec_t vq[$];

    // model state: hist[0] is the newest bit
    int           hist[$];
    logic [N-1:0] mm0;
    logic [N-1:0] mm1;

    conv_encoder #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .load_mask (load_mask),
        .mask      (mask),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic par(input logic [N-1:0] m);
        int acc;
        acc = 0;
        for (int i = 0; i < N; i++) begin
            // mask bit N-1 taps the newest bit, bit 0 the oldest
            if (m[i] && hist[N-1-i] != 0) acc++;
        end
        return logic'(acc % 2);
    endfunction

    task automatic model_edge(input logic r, input logic d,
                              input logic [1:0] lm,
                              input logic [N-1:0] mk);
        if (!r) begin
            hist.delete();
            for (int i = 0; i < N; i++) hist.push_back(0);
        end else begin
            hist.push_front(d ? 1 : 0);
            void'(hist.pop_back());
        end
        if (lm[0]) mm0 = mk;
        if (lm[1]) mm1 = mk;
    endtask

    task automatic add(input logic r, input logic d,
                       input logic [1:0] lm,
                       input logic [N-1:0] mk,
                       input logic [1:0] e);
        vec_t v;
        v.rst = r;
        v.d   = d;
        v.lm  = lm;
        v.mk  = mk;
        v.exp = e;
        vq.push_back(v);
    endtask

    task automatic drive(input logic r, input logic d,
                         input logic [1:0] lm,
                         input logic [N-1:0] mk);
        reset     = r;
        data_in   = d;
        load_mask = lm;
        mask      = mk;
        @(posedge clk);
        model_edge(r, d, lm, mk);
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] mexp;
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < N; i++) hist.push_back(0);
        mm0 = '0;
        mm1 = '0;

        // mask load under reset, then zeros
        add(0, 0, 2'b01, 4'b1101, 2'b00);
        add(0, 1, 2'b10, 4'b1111, 2'b00);
        add(1, 0, 2'b00, 4'b0000, 2'b00);
        add(1, 0, 2'b00, 4'b0000, 2'b00);
        add(1, 0, 2'b00, 4'b0000, 2'b00);
        add(1, 0, 2'b00, 4'b0000, 2'b00);
        // sequence 1,0,1,1,0,0,0,0
        add(1, 1, 2'b00, 4'b0000, 2'b11);
        add(1, 0, 2'b00, 4'b0000, 2'b11);
        add(1, 1, 2'b00, 4'b0000, 2'b01);
        add(1, 1, 2'b00, 4'b0000, 2'b11);
        add(1, 0, 2'b00, 4'b0000, 2'b01);
        add(1, 0, 2'b00, 4'b0000, 2'b01);
        add(1, 0, 2'b00, 4'b0000, 2'b11);
        add(1, 0, 2'b00, 4'b0000, 2'b00);
        // impulse response: sr 1000,0100,0010,0001,0000
        add(1, 1, 2'b00, 4'b0000, 2'b11);
        add(1, 0, 2'b00, 4'b0000, 2'b11);
        add(1, 0, 2'b00, 4'b0000, 2'b10);
        add(1, 0, 2'b00, 4'b0000, 2'b11);
        add(1, 0, 2'b00, 4'b0000, 2'b00);
        // reset mid-stream, masks retained
        add(1, 1, 2'b00, 4'b0000, 2'b11);
        add(1, 1, 2'b00, 4'b0000, 2'b00);
        add(0, 1, 2'b00, 4'b0000, 2'b00);
        add(1, 1, 2'b00, 4'b0000, 2'b11);
        add(1, 0, 2'b00, 4'b0000, 2'b11);
        add(1, 0, 2'b00, 4'b0000, 2'b10);
        add(1, 0, 2'b00, 4'b0000, 2'b11);
        add(1, 0, 2'b00, 4'b0000, 2'b00);
        // build sr=1010, then reload m1=1000 while shifting 0
        add(1, 1, 2'b00, 4'b0000, 2'b11);
        add(1, 0, 2'b00, 4'b0000, 2'b11);
        add(1, 1, 2'b00, 4'b0000, 2'b01);
        add(1, 0, 2'b10, 4'b1000, 2'b00);
        add(1, 0, 2'b00, 4'b0000, 2'b00);
        add(1, 0, 2'b10, 4'b1111, 2'b11);
        add(1, 0, 2'b00, 4'b0000, 2'b00);
        // load both with 1011, then restore o15/o17
        add(1, 1, 2'b11, 4'b1011, 2'b11);
        add(1, 0, 2'b00, 4'b0000, 2'b00);
        add(1, 0, 2'b00, 4'b0000, 2'b11);
        add(1, 0, 2'b00, 4'b0000, 2'b11);
        add(1, 0, 2'b01, 4'b1101, 2'b00);
        add(1, 0, 2'b10, 4'b1111, 2'b00);

        reset     = 1'b0;
        data_in   = 1'b0;
        load_mask = 2'b00;
        mask      = '0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].d, vq[i].lm, vq[i].mk);
            n_cmp++;
            if (data_out !== vq[i].exp) begin
                n_err++;
                $display("FAIL vec%0d: data_out=%b expected=%b",
                         i, data_out, vq[i].exp);
            end
        end

        // random regression with occasional reloads and resets
        for (int i = 0; i < 1000; i++) begin
            logic         r;
            logic         d;
            logic [1:0]   lm;
            logic [N-1:0] mk;
            r  = ($urandom_range(63) != 0);
            d  = logic'($urandom_range(1));
            lm = ($urandom_range(7) == 0) ?
                 2'($urandom_range(3)) : 2'b00;
            mk = N'($urandom);
            drive(r, d, lm, mk);
            mexp = {par(mm1), par(mm0)};
            n_cmp++;
            if (data_out !== mexp) begin
                n_err++;
                $display("FAIL rand%0d: data_out=%b expected=%b",
                         i, data_out, mexp);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
